ebpf_decode_stage: RTL and testbench

- Registered, handshaked eBPF instruction decode stage between fetch and execute.
- Splits each 64-bit slot into op/dst/src/off/imm with parametrised sign-extension width.
- Assembles two-slot LDDW (op 0x18) into one 64-bit immediate.
- Tracks a slot-granular PC, supports synchronous flush on taken branches, and provides one output register with valid/ready backpressure.

---
 rtl/ebpf_decode_stage.sv | 214 +++++++++++++++++++++
 tb/tb_ebpf_decode_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebpf_decode_stage.sv
// eBPF instruction decode stage: one registered output slot with
// valid/ready backpressure, LDDW pairing, slot PC tracking and flush.
// Optional class outputs (cls, is_ld, is_st, is_alu, is_jmp) are
// compiled in when the macro DECODE_CLASS_EN is defined.
module ebpf_decode_stage #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 16,
    parameter int SRC_W  = 4,
    parameter int DST_W  = 4,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   op,
    output logic [DST_W-1:0]  dst,
    output logic [SRC_W-1:0]  src,
    output logic [DATA_W-1:0] off,
    output logic [DATA_W-1:0] imm,
    output logic [PC_W-1:0]   pc,
    output logic              wide,
`ifdef DECODE_CLASS_EN
    output logic [2:0]        cls,
    output logic              is_ld,
    output logic              is_st,
    output logic              is_alu,
    output logic              is_jmp,
`endif
    output logic              err
);

    localparam logic [7:0] OP_LDDW = 8'h18;
    localparam logic [7:0] OP_HI   = 8'h00;

    typedef enum logic {
        S_LO,
        S_HI
    } state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_cnt_q;
    logic              out_valid_q;
    logic [OP_W-1:0]   op_q;
    logic [DST_W-1:0]  dst_q;
    logic [SRC_W-1:0]  src_q;
    logic [DATA_W-1:0] off_q;
    logic [DATA_W-1:0] imm_q;
    logic [PC_W-1:0]   pc_q;
    logic              wide_q;
    logic              err_q;

    // Low half of an LDDW held while waiting for its second slot
    logic [7:0]        lo_op_q;
    logic [3:0]        lo_dst_q;
    logic [3:0]        lo_src_q;
    logic [15:0]       lo_off_q;
    logic [31:0]       lo_imm_q;
    logic [PC_W-1:0]   lo_pc_q;

    logic              acc;
    logic              in_is_lddw;
    logic              hi_ok;
    logic signed [15:0] in_off16;
    logic signed [31:0] in_imm32;
    logic signed [15:0] lo_off16;
    logic signed [31:0] lo_imm32;
    logic signed [63:0] pair64;
    logic [DATA_W-1:0] in_off_x;
    logic [DATA_W-1:0] in_imm_x;
    logic [DATA_W-1:0] lo_off_x;
    logic [DATA_W-1:0] lo_imm_x;
    logic [DATA_W-1:0] pair_x;

    assign in_ready   = !out_valid_q || out_ready;
    assign acc        = in_valid && in_ready;
    assign in_is_lddw = (instr[7:0] == OP_LDDW);
    assign hi_ok      = (instr[7:0] == OP_HI);

    assign in_off16 = instr[31:16];
    assign in_imm32 = instr[63:32];
    assign lo_off16 = lo_off_q;
    assign lo_imm32 = lo_imm_q;
    assign pair64   = {instr[63:32], lo_imm_q};

    assign in_off_x = DATA_W'(in_off16);
    assign in_imm_x = DATA_W'(in_imm32);
    assign lo_off_x = DATA_W'(lo_off16);
    assign lo_imm_x = DATA_W'(lo_imm32);
    assign pair_x   = DATA_W'(pair64);

`ifdef DECODE_CLASS_EN
    logic [2:0] cls_q;
    logic [3:0] flags_q;

    // One-hot {ld, st, alu, jmp} from the 3-bit opcode class
    function automatic logic [3:0] class_flags(input logic [2:0] c);
        logic [3:0] f;
        f = 4'b0000;
        unique case (c)
            3'd0, 3'd1: f = 4'b1000;
            3'd2, 3'd3: f = 4'b0100;
            3'd4, 3'd7: f = 4'b0010;
            3'd5, 3'd6: f = 4'b0001;
            default:    f = 4'b0000;
        endcase
        return f;
    endfunction

    assign cls    = cls_q;
    assign is_ld  = flags_q[3];
    assign is_st  = flags_q[2];
    assign is_alu = flags_q[1];
    assign is_jmp = flags_q[0];
`endif

    // Slot FSM, PC counter, LDDW capture and the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LO;
            pc_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            off_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            wide_q      <= 1'b0;
            err_q       <= 1'b0;
            lo_op_q     <= '0;
            lo_dst_q    <= '0;
            lo_src_q    <= '0;
            lo_off_q    <= '0;
            lo_imm_q    <= '0;
            lo_pc_q     <= '0;
`ifdef DECODE_CLASS_EN
            cls_q       <= '0;
            flags_q     <= '0;
`endif
        end else if (flush) begin
            state_q     <= S_LO;
            pc_cnt_q    <= flush_pc;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (acc) begin
                pc_cnt_q <= pc_cnt_q + PC_W'(1);
                unique case (state_q)
                    S_LO: begin
                        if (in_is_lddw) begin
                            lo_op_q  <= instr[7:0];
                            lo_dst_q <= instr[11:8];
                            lo_src_q <= instr[15:12];
                            lo_off_q <= instr[31:16];
                            lo_imm_q <= instr[63:32];
                            lo_pc_q  <= pc_cnt_q;
                            state_q  <= S_HI;
                        end else begin
                            op_q        <= OP_W'(instr[7:0]);
                            dst_q       <= DST_W'(instr[11:8]);
                            src_q       <= SRC_W'(instr[15:12]);
                            off_q       <= in_off_x;
                            imm_q       <= in_imm_x;
                            pc_q        <= pc_cnt_q;
                            wide_q      <= 1'b0;
                            err_q       <= 1'b0;
                            out_valid_q <= 1'b1;
`ifdef DECODE_CLASS_EN
                            cls_q   <= instr[2:0];
                            flags_q <= class_flags(instr[2:0]);
`endif
                        end
                    end
                    S_HI: begin
                        op_q        <= OP_W'(lo_op_q);
                        dst_q       <= DST_W'(lo_dst_q);
                        src_q       <= SRC_W'(lo_src_q);
                        off_q       <= lo_off_x;
                        imm_q       <= hi_ok ? pair_x : lo_imm_x;
                        pc_q        <= lo_pc_q;
                        wide_q      <= 1'b1;
                        err_q       <= !hi_ok;
                        out_valid_q <= 1'b1;
                        state_q     <= S_LO;
`ifdef DECODE_CLASS_EN
                        cls_q   <= lo_op_q[2:0];
                        flags_q <= class_flags(lo_op_q[2:0]);
`endif
                    end
                    default: state_q <= S_LO;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign op        = op_q;
    assign dst       = dst_q;
    assign src       = src_q;
    assign off       = off_q;
    assign imm       = imm_q;
    assign pc        = pc_q;
    assign wide      = wide_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ebpf_decode_stage.sv
// Bench for ebpf_decode_stage: directed steps plus random traffic
// checked against a slot-stream reference model.
module tb_ebpf_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] flush_pc;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [63:0] off;
    logic [63:0] imm;
    logic [15:0] pc;
    logic        wide;
    logic        err;
`ifdef DECODE_CLASS_EN
    logic [2:0]  cls;
    logic        is_ld, is_st, is_alu, is_jmp;
`endif

    always #5 clk = ~clk;

    ebpf_decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .dst       (dst),
        .src       (src),
        .off       (off),
        .imm       (imm),
        .pc        (pc),
        .wide      (wide),
`ifdef DECODE_CLASS_EN
        .cls       (cls),
        .is_ld     (is_ld),
        .is_st     (is_st),
        .is_alu    (is_alu),
        .is_jmp    (is_jmp),
`endif
        .err       (err)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [63:0] off;
        logic [63:0] imm;
        logic [15:0] pc;
        logic        wide;
        logic        err;
    } rec_t;

    rec_t        q[$];
    int          nerr = 0;
    int          nchk = 0;
    int          ntx  = 0;
    logic        pend;
    logic [63:0] pslot;
    logic [15:0] ppc;
    logic [15:0] mpc;

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return v[31] ? {32'hFFFF_FFFF, v} : {32'h0, v};
    endfunction

    function automatic logic [63:0] sx16(input logic [15:0] v);
        return v[15] ? {48'hFFFF_FFFF_FFFF, v} : {48'h0, v};
    endfunction

    task automatic check(input string tag, input logic [161:0] obs,
                         input logic [161:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [63:0] s, input logic [15:0] p,
                                input logic [63:0] im, input logic w,
                                input logic e);
        rec_t r;
        r.op   = s[7:0];
        r.dst  = s[11:8];
        r.src  = s[15:12];
        r.off  = sx16(s[31:16]);
        r.imm  = im;
        r.pc   = p;
        r.wide = w;
        r.err  = e;
        return r;
    endfunction

    // Turns the accepted slot stream into expected instructions
    task automatic model_slot(input logic [63:0] s);
        if (!pend) begin
            if (s[7:0] == 8'h18) begin
                pend  = 1'b1;
                pslot = s;
                ppc   = mpc;
            end else begin
                q.push_back(mk(s, mpc, sx32(s[63:32]), 1'b0, 1'b0));
            end
        end else begin
            if (s[7:0] == 8'h00)
                q.push_back(mk(pslot, ppc, {s[63:32], pslot[63:32]}, 1'b1, 1'b0));
            else
                q.push_back(mk(pslot, ppc, sx32(pslot[63:32]), 1'b1, 1'b1));
            pend = 1'b0;
        end
        mpc = mpc + 16'd1;
    endtask

    task automatic step(input logic v, input logic [63:0] s, input logic r,
                        input logic f, input logic [15:0] fpc);
        in_valid  = v;
        instr     = s;
        out_ready = r;
        flush     = f;
        flush_pc  = fpc;
        @(negedge clk);
        if (rst) begin
            q.delete();
            pend = 1'b0;
            mpc  = 16'd0;
        end else begin
            check("valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && q.size() != 0)
                check("out", {op, dst, src, off, imm, pc, wide, err}, q[0]);
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
                ntx++;
            end
            if (f) begin
                q.delete();
                pend = 1'b0;
                mpc  = fpc;
            end else if (v && in_ready) begin
                model_slot(s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 64'h0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 16'h0);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 64'h0, 1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        int base;
        logic [63:0] s;
        rst = 1'b1; flush = 1'b0; flush_pc = '0;
        in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        pend = 1'b0; pslot = '0; ppc = '0; mpc = '0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_data", {op, dst, src, off, imm, pc, wide, err}, 162'h0);

        // Basic mov
        step(1'b1, 64'h0000_0005_FFFE_21B7, 1'b1, 1'b0, 16'h0);
        check("t1_valid", out_valid, 1'b1);
        check("t1_op", op, 8'hB7);
        check("t1_dst", dst, 4'd1);
        check("t1_src", src, 4'd2);
        check("t1_off", off, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t1_imm", imm, 64'd5);
        check("t1_pc", pc, 16'd0);
        idle(1);

        // Well-formed LDDW
        do_reset();
        step(1'b1, 64'h1234_5678_0000_0118, 1'b1, 1'b0, 16'h0);
        check("t2_novalid", out_valid, 1'b0);
        step(1'b1, 64'h9ABC_DEF0_0000_0000, 1'b1, 1'b0, 16'h0);
        check("t2_valid", out_valid, 1'b1);
        check("t2_imm", imm, 64'h9ABC_DEF0_1234_5678);
        check("t2_we", {wide, err}, 2'b10);
        check("t2_pc", pc, 16'd0);
        check("t2_op", {op, dst}, 12'h181);
        idle(1);
        step(1'b1, 64'h0000_0001_0000_0007, 1'b1, 1'b0, 16'h0);
        check("t2_cnt", pc, 16'd2);
        idle(1);

        // Malformed LDDW
        do_reset();
        step(1'b1, 64'h8000_0000_0000_0018, 1'b1, 1'b0, 16'h0);
        step(1'b1, 64'h0000_0000_0000_0007, 1'b1, 1'b0, 16'h0);
        check("t3_we", {wide, err}, 2'b11);
        check("t3_imm", imm, 64'hFFFF_FFFF_8000_0000);
        idle(1);

        // Backpressure
        do_reset();
        base = ntx;
        step(1'b1, 64'h0000_00AA_0000_0107, 1'b0, 1'b0, 16'h0);
        check("t4_ready", in_ready, 1'b0);
        step(1'b1, 64'h0000_00BB_0000_0207, 1'b0, 1'b0, 16'h0);
        check("t4_hold", {imm, pc}, {64'hAA, 16'd0});
        step(1'b1, 64'h0000_00BB_0000_0207, 1'b0, 1'b0, 16'h0);
        step(1'b1, 64'h0000_00BB_0000_0207, 1'b1, 1'b0, 16'h0);
        check("t4_pc1", {imm, pc}, {64'hBB, 16'd1});
        step(1'b1, 64'h0000_00CC_0000_0307, 1'b1, 1'b0, 16'h0);
        check("t4_pc2", {imm, pc}, {64'hCC, 16'd2});
        idle(2);
        check("t4_count", ntx - base, 3);

        // Flush while holding an LDDW low half
        do_reset();
        step(1'b1, 64'hDEAD_BEEF_0000_0318, 1'b1, 1'b0, 16'h0);
        step(1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 16'h0040);
        check("t5_flushed", out_valid, 1'b0);
        step(1'b1, 64'h0000_0011_0000_0500, 1'b1, 1'b0, 16'h0);
        check("t5_valid", out_valid, 1'b1);
        check("t5_pc", pc, 16'h0040);
        check("t5_imm", imm, 64'h11);
        check("t5_we", {wide, err, op}, 10'h0);
        idle(1);

`ifdef DECODE_CLASS_EN
        do_reset();
        check("cls_rst", {cls, is_ld, is_st, is_alu, is_jmp}, 7'h0);
        step(1'b1, 64'h0000_0000_0000_0095, 1'b1, 1'b0, 16'h0);
        check("cls_exit", {cls, is_ld, is_st, is_alu, is_jmp}, {3'd5, 4'b0001});
        step(1'b1, 64'h0000_0000_0000_0061, 1'b1, 1'b0, 16'h0);
        check("cls_ld", {cls, is_ld, is_st, is_alu, is_jmp}, {3'd1, 4'b1000});
        idle(1);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int sel;
            s   = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel < 2)       s[7:0] = 8'h18;
            else if (sel == 2) s[7:0] = 8'h00;
            step(($urandom % 4) != 0, s, ($urandom % 4) != 0,
                 ($urandom % 64) == 0,
                 16'($urandom_range(16'hFFF0, 16'hFFFF)));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
